mips_mem_arbiter: RTL and testbench

- Shares one unified memory port between the MIPS instruction-fetch path and the data load/store path, replacing split imem/dmem.
- Sits between the core and a single memory with variable latency.
- Handles one outstanding transaction, with selectable fixed or round-robin priority, a response timeout and a conflict counter.
- Requesters stall on their own req until they receive ack.

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/mips_mem_arbiter_if.sv | 45 ++++
 rtl/mips_rr_pick.sv | 27 ++
 rtl/mips_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and default widths for the unified instruction/data memory
// arbiter. Imported by the interface, the picker and the arbiter top.
package mips_mem_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_sel_t;

  function automatic port_sel_t other_port(input port_sel_t p);
    return (p == PORT_IF) ? PORT_D : PORT_IF;
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bundle of every non-clock signal of mips_mem_arbiter: fetch port, data
// port, memory port and status.
//   slave  : the arbiter (consumes core requests and memory completions)
//   master : the environment (core requesters + memory)
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = mips_mem_pkg::DEF_ADDR_W,
  parameter int DATA_W = mips_mem_pkg::DEF_DATA_W,
  parameter int CNT_W  = mips_mem_pkg::DEF_CNT_W
) ();
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  // data port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  // memory port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  // status
  logic              stall;
  logic              err;
  logic [CNT_W-1:0]  conflict_cnt;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall, err, conflict_cnt
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata,
           stall, err, conflict_cnt
  );
endinterface

// File: rtl/mips_rr_pick.sv
// Two-input grant picker for the fetch and data ports.
//   if_req, d_req : pending requests
//   last_grant    : port served by the previous grant
//   sel           : winning port (only meaningful when a request is pending)
//   tie           : both ports requesting this cycle
// RR_MODE=0: data always wins a tie. RR_MODE=1: a tie goes to the port that
// was not granted last.
module mips_rr_pick
  import mips_mem_pkg::*;
#(
  parameter int RR_MODE = 0
) (
  input  logic      if_req,
  input  logic      d_req,
  input  port_sel_t last_grant,
  output port_sel_t sel,
  output logic      tie
);

  always_comb begin
    tie = if_req & d_req;
    sel = PORT_IF;
    if (tie)        sel = (RR_MODE != 0) ? other_port(last_grant) : PORT_D;
    else if (d_req) sel = PORT_D;
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Unified memory port arbiter between MIPS instruction fetch and data
// load/store. One transaction in flight: IDLE arbitrates and latches the
// request, ISSUE pulses mem_req, WAIT collects the completion (or times out),
// RESP pulses the winner's ack. Requesters hold req until their ack.
//   clock, reset : rising-edge clock, async active-low reset
//   bus          : fetch/data/memory/status signals (slave side)
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RR_MODE = 0,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clock,
  input  logic               reset,
  mips_mem_arbiter_if.slave  bus
);

  // wait counter only needs to reach TIMEOUT-1
  localparam int WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t        state_q,     state_d;
  port_sel_t         gnt_q,       gnt_d;      // doubles as last_grant
  logic [WCNT_W-1:0] wcnt_q,      wcnt_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
  logic              if_ack_q,    if_ack_d;
  logic              d_ack_q,     d_ack_d;
  logic              err_q,       err_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  port_sel_t pick_sel;
  logic      pick_tie;
  logic      resp_go;

  mips_rr_pick #(.RR_MODE(RR_MODE)) u_pick (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .last_grant (gnt_q),
    .sel        (pick_sel),
    .tie        (pick_tie)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    wcnt_d      = wcnt_q;
    mem_req_d   = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    resp_go     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req | bus.d_req) begin
          gnt_d     = pick_sel;
          state_d   = ISSUE;
          mem_req_d = 1'b1;     // registered so the pulse lines up with ISSUE
          if (pick_sel == PORT_D) begin
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
          end
          if (pick_tie && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          // store completions leave the port's read data untouched
          if (!mem_we_q) begin
            if (gnt_q == PORT_D) d_rdata_d  = bus.mem_rdata;
            else                 if_rdata_d = bus.mem_rdata;
          end
          state_d = RESP;
          resp_go = 1'b1;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          err_d = 1'b1;
          if (gnt_q == PORT_D) d_rdata_d  = '0;
          else                 if_rdata_d = '0;
          state_d = RESP;
          resp_go = 1'b1;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // ack flops are set on entry to RESP so they are high exactly in RESP
    if_ack_d = resp_go && (gnt_q == PORT_IF);
    d_ack_d  = resp_go && (gnt_q == PORT_D);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= PORT_IF;
      wcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      wcnt_q      <= wcnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.if_rdata     = if_rdata_q;
  assign bus.if_ack       = if_ack_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.d_ack        = d_ack_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.err          = err_q;
  assign bus.conflict_cnt = cnt_q;
  assign bus.stall        = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter. dut (RR_MODE=1, TIMEOUT=8) runs directed
// table vectors, round-robin ties, a reset in WAIT and a randomized phase
// against a transaction-level model; dut0 (RR_MODE=0, CNT_W=2) covers
// data-priority ties and counter saturation.
module tb_mips_mem_arbiter;
  import mips_mem_pkg::*;

  localparam int AW = 32, DW = 32, CW = 16, TO = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus  ();
  mips_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2))  bus0 ();

  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .TIMEOUT(TO), .CNT_W(CW))
    dut  (.clock(clock), .reset(reset), .bus(bus));
  mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .TIMEOUT(TO), .CNT_W(2))
    dut0 (.clock(clock), .reset(reset), .bus(bus0));

  int n_chk = 0, n_err = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C02_0004;
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  // memory models: dut memory answers mem_lat cycles after mem_req
  // (0 = never), dut0 memory always answers one cycle after mem_req
  int          mem_lat = 1, mem_cd = 0;
  logic [31:0] mem_raddr = '0, r0_addr = '0;
  bit          stray = 0, r0_pend = 0;

  task automatic tick();
    @(negedge clock);
    cyc++;
    bus.mem_rvalid = 1'b0;
    if (mem_cd > 0) begin
      mem_cd--;
      if (mem_cd == 0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = mem_val(mem_raddr); end
    end else if (stray) begin
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
    end
    stray = 0;
    if (bus.mem_req) begin mem_cd = mem_lat; mem_raddr = bus.mem_addr; end
    bus0.mem_rvalid = r0_pend;
    bus0.mem_rdata  = mem_val(r0_addr);
    r0_pend = bus0.mem_req;
    if (bus0.mem_req) r0_addr = bus0.mem_addr;
  endtask

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_cyc;    // ticks from the sampling IDLE cycle to ack
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;
  vec_t vecs[6];

  // transaction-level model state for the random phase
  bit          busy, m_port, t_we;   // m_port: 0 = fetch, 1 = data
  bit          m_last;
  int          m_issue, m_resp, m_lat, m_cnt;
  bit          m_err;
  logic [31:0] t_addr, t_wdata, exp_if_rd, exp_d_rd;

  initial begin
    bit e_ifack, e_dack, e_mreq, tie;
    int acked_at, nreq, nd;
    bit got, early;
    logic [1:0] order;

    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    bus0.if_req = 0; bus0.if_addr = '0; bus0.d_req = 0; bus0.d_we = 0;
    bus0.d_addr = '0; bus0.d_wdata = '0; bus0.mem_rvalid = 0; bus0.mem_rdata = '0;

    vecs[0] = '{0, 0, 32'h40,  32'h0, 1, 3,  32'h8C02_0004, 0};
    vecs[1] = '{1, 0, 32'h100, 32'h0, 2, 4,  32'hC0DE_0100, 0};
    vecs[2] = '{1, 1, 32'h54,  32'h7, 1, 3,  32'hC0DE_0100, 0};  // store keeps d_rdata
    vecs[3] = '{0, 0, 32'h80,  32'h0, 4, 6,  32'hC0DE_0080, 0};
    vecs[4] = '{1, 0, 32'h200, 32'h0, 0, 10, 32'h0,         1};  // timeout
    vecs[5] = '{0, 0, 32'h44,  32'h0, 1, 3,  32'hC0DE_0044, 1};  // err sticky

    // ---- reset state
    repeat (3) tick();
    chk("rst if_ack", bus.if_ack, 0);       chk("rst d_ack", bus.d_ack, 0);
    chk("rst mem_req", bus.mem_req, 0);     chk("rst mem_we", bus.mem_we, 0);
    chk("rst mem_addr", bus.mem_addr, 0);   chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst if_rdata", bus.if_rdata, 0);   chk("rst d_rdata", bus.d_rdata, 0);
    chk("rst err", bus.err, 0);             chk("rst cnt", bus.conflict_cnt, 0);
    chk("rst stall", bus.stall, 0);
    reset = 1'b1;
    tick();

    // ---- table: solitary transactions
    for (int i = 0; i < 6; i++) begin
      mem_lat = vecs[i].lat;
      if (vecs[i].is_d) begin
        bus.d_req = 1; bus.d_we = vecs[i].we; bus.d_addr = vecs[i].addr; bus.d_wdata = vecs[i].wdata;
      end else begin
        bus.if_req = 1; bus.if_addr = vecs[i].addr;
      end
      acked_at = 0; nreq = 0;
      for (int k = 1; k <= 30 && acked_at == 0; k++) begin
        tick();
        if (bus.mem_req) begin
          nreq++;
          chk("vec mem_addr", bus.mem_addr, vecs[i].addr);
          chk("vec mem_we", bus.mem_we, vecs[i].we);
          if (vecs[i].we) chk("vec mem_wdata", bus.mem_wdata, vecs[i].wdata);
        end
        chk("vec other ack", vecs[i].is_d ? bus.if_ack : bus.d_ack, 0);
        got = vecs[i].is_d ? bus.d_ack : bus.if_ack;
        chk("vec stall", bus.stall, !got);
        if (got) acked_at = k;
      end
      bus.if_req = 0; bus.d_req = 0;
      chk("vec latency", acked_at, vecs[i].exp_cyc);
      chk("vec mem_req pulses", nreq, 1);
      chk("vec rdata", vecs[i].is_d ? bus.d_rdata : bus.if_rdata, vecs[i].exp_rdata);
      chk("vec err", bus.err, vecs[i].exp_err);
      tick();
    end
    chk("vec no ties", bus.conflict_cnt, 0);

    // ---- late/stray rvalid in IDLE is ignored
    stray = 1;
    got = 0;
    repeat (3) begin tick(); if (bus.if_ack | bus.d_ack) got = 1; end
    chk("stray ack", got, 0);
    chk("stray d_rdata", bus.d_rdata, 0);
    chk("stray if_rdata", bus.if_rdata, 32'hC0DE_0044);

    // ---- RR_MODE=1 ties: last grant was fetch, so D, IF, D, IF
    mem_lat = 1;
    bus.if_addr = 32'h300; bus.d_addr = 32'h400; bus.d_we = 0;
    bus.if_req = 1; bus.d_req = 1;
    nd = 0; early = 0;
    for (int k = 0; k < 60 && nd < 4; k++) begin
      tick();
      if (bus.if_ack & bus.d_ack) early = 1;
      if (bus.if_ack | bus.d_ack) begin
        order = {1'b0, bus.d_ack};
        chk("rr order", order, (nd % 2 == 0) ? 2'd1 : 2'd0);
        nd++;
        chk("rr cnt", bus.conflict_cnt, nd);
        if (nd == 4) begin bus.if_req = 0; bus.d_req = 0; end
      end
    end
    chk("rr acks", nd, 4);
    chk("rr dual ack", early, 0);
    chk("rr if_rdata", bus.if_rdata, 32'hC0DE_0300);
    chk("rr d_rdata", bus.d_rdata, 32'hC0DE_0400);
    tick();

    // ---- RR_MODE=0 ties on dut0: data always wins, CNT_W=2 saturates at 3
    bus0.if_addr = 32'h600; bus0.d_addr = 32'h700; bus0.if_req = 1; bus0.d_req = 1;
    nd = 0; early = 0;
    for (int k = 0; k < 60 && nd < 4; k++) begin
      tick();
      if (bus0.if_ack) early = 1;
      if (bus0.d_ack) begin
        nd++;
        chk("rr0 cnt", bus0.conflict_cnt, (nd > 3) ? 3 : nd);
        chk("rr0 d_rdata", bus0.d_rdata, 32'hC0DE_0700);
        if (nd == 4) bus0.d_req = 0;
      end
    end
    chk("rr0 d acks", nd, 4);
    chk("rr0 if_ack while d held", early, 0);
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin tick(); if (bus0.if_ack) got = 1; end
    bus0.if_req = 0;
    chk("rr0 if served", got, 1);
    chk("rr0 cnt final", bus0.conflict_cnt, 3);
    chk("rr0 if_rdata", bus0.if_rdata, 32'hC0DE_0600);
    tick();

    // ---- reset while in WAIT
    mem_lat = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    bus.d_req = 0;
    chk("rstw if_ack", bus.if_ack, 0);     chk("rstw d_ack", bus.d_ack, 0);
    chk("rstw mem_req", bus.mem_req, 0);   chk("rstw mem_we", bus.mem_we, 0);
    chk("rstw mem_addr", bus.mem_addr, 0); chk("rstw mem_wdata", bus.mem_wdata, 0);
    chk("rstw if_rdata", bus.if_rdata, 0); chk("rstw d_rdata", bus.d_rdata, 0);
    chk("rstw err", bus.err, 0);           chk("rstw cnt", bus.conflict_cnt, 0);
    repeat (2) tick();
    reset = 1'b1;
    stray = 1;
    got = 0;
    repeat (3) begin tick(); if (bus.if_ack | bus.d_ack) got = 1; end
    chk("rstw stray ack", got, 0);
    mem_lat = 1;
    bus.if_req = 1; bus.if_addr = 32'h40;
    acked_at = 0;
    for (int k = 1; k <= 20 && acked_at == 0; k++) begin tick(); if (bus.if_ack) acked_at = k; end
    bus.if_req = 0;
    chk("rstw next latency", acked_at, 3);
    chk("rstw next rdata", bus.if_rdata, 32'h8C02_0004);

    // ---- randomized phase against a transaction-level model
    busy = 0; m_last = 0; m_cnt = 0; m_err = 0; m_resp = cyc; m_issue = cyc; m_lat = 1;
    exp_if_rd = 32'h8C02_0004; exp_d_rd = '0;
    t_we = 0; t_addr = '0; t_wdata = '0; m_port = 0;
    for (int n = 0; n < 1500; n++) begin
      tick();
      e_mreq = busy && (cyc == m_issue);
      e_ifack = 0; e_dack = 0;
      if (busy && cyc == m_resp) begin
        if (m_lat == 0) begin
          m_err = 1;
          if (m_port) exp_d_rd = '0; else exp_if_rd = '0;
        end else if (!t_we) begin
          if (m_port) exp_d_rd = mem_val(t_addr); else exp_if_rd = mem_val(t_addr);
        end
        if (m_port) e_dack = 1; else e_ifack = 1;
      end
      chk("rnd if_ack", bus.if_ack, e_ifack);
      chk("rnd d_ack", bus.d_ack, e_dack);
      chk("rnd mem_req", bus.mem_req, e_mreq);
      chk("rnd if_rdata", bus.if_rdata, exp_if_rd);
      chk("rnd d_rdata", bus.d_rdata, exp_d_rd);
      chk("rnd err", bus.err, m_err);
      chk("rnd cnt", bus.conflict_cnt, m_cnt);
      chk("rnd stall", bus.stall, (bus.if_req & ~e_ifack) | (bus.d_req & ~e_dack));
      if (e_mreq) begin
        chk("rnd mem_addr", bus.mem_addr, t_addr);
        chk("rnd mem_we", bus.mem_we, t_we);
        if (t_we) chk("rnd mem_wdata", bus.mem_wdata, t_wdata);
      end
      // requesters: hold until ack, then maybe continue back-to-back
      if (e_ifack) busy = 0;
      if (e_dack)  busy = 0;
      if ((e_ifack && $urandom_range(0, 1) == 1) || (!bus.if_req && $urandom_range(0, 2) == 0)) begin
        bus.if_req = 1; bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (e_ifack) bus.if_req = 0;
      if ((e_dack && $urandom_range(0, 1) == 1) || (!bus.d_req && $urandom_range(0, 2) == 0)) begin
        bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1));
        bus.d_addr = $urandom & 32'hFFFF_FFFC; bus.d_wdata = $urandom;
      end else if (e_dack) bus.d_req = 0;
      // arbitration happens in the cycle after a response
      if (!busy && cyc > m_resp && (bus.if_req || bus.d_req)) begin
        tie = bus.if_req && bus.d_req;
        m_port = tie ? ~m_last : bus.d_req;
        if (tie) m_cnt++;
        m_last  = m_port;
        t_we    = m_port ? bus.d_we : 1'b0;
        t_addr  = m_port ? bus.d_addr : bus.if_addr;
        t_wdata = bus.d_wdata;
        m_lat   = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
        mem_lat = m_lat;
        m_issue = cyc + 1;
        m_resp  = cyc + 2 + ((m_lat == 0) ? TO : m_lat);
        busy    = 1;
      end
      if (!(busy && cyc + 1 >= m_issue && cyc + 1 < m_resp) && $urandom_range(0, 9) == 0)
        stray = 1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
